servo_pwm: RTL



---
 rtl/servo_pwm.sv | 110 +++++++++++
 1 files changed

// File: rtl/servo_pwm.sv
// Servo PWM generator: fixed frame, high time MIN_TICKS + cur_angle*DEG_TICKS, angle latched per frame.
// Optional build macro SERVO_CLAMP_EN limits the latched angle to 180 degrees.
module servo_pwm #(
   parameter int FRAME_TICKS = 1_000_000,
   parameter int MIN_TICKS   = 50_000,
   parameter int DEG_TICKS   = 278
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] angle,
   input  logic       en,
   output logic       pwm,
   output logic       frame_start,
   output logic [7:0] cur_angle
);

   localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
   localparam logic [FW-1:0] MIN_LAST   = FW'(MIN_TICKS - 1);
   localparam logic [FW-1:0] DEG_LAST   = FW'(DEG_TICKS - 1);
   localparam logic [FW-1:0] ONE        = FW'(1);

   typedef enum logic [1:0] {IDLE, BASE, DEG, LOW} state_t;

   state_t        state, state_next;
   logic [FW-1:0] fcnt;
   logic [FW-1:0] bcnt, bcnt_next;
   logic [FW-1:0] pcnt, pcnt_next;
   logic [7:0]    dcnt, dcnt_next, dcnt_inc;
   logic          en_q;
   logic          boundary;
   logic          pwm_next;

   function automatic logic [7:0] clamp_angle(input logic [7:0] a);
`ifdef SERVO_CLAMP_EN
      return (a > 8'd180) ? 8'd180 : a;
`else
      return a;
`endif
   endfunction

   assign boundary = (fcnt == '0);
   assign dcnt_inc = dcnt + 8'd1;

   // Frame boundary always wins, so a pulse can never spill into the next frame.
   always_comb begin
      state_next = state;
      bcnt_next  = bcnt;
      pcnt_next  = pcnt;
      dcnt_next  = dcnt;
      if (boundary) begin
         state_next = en ? BASE : LOW;
         bcnt_next  = '0;
         pcnt_next  = '0;
         dcnt_next  = '0;
      end else begin
         case (state)
            BASE: begin
               if (!en_q) begin
                  state_next = LOW;
               end else if (bcnt == MIN_LAST) begin
                  state_next = (cur_angle == 8'd0) ? LOW : DEG;
                  pcnt_next  = '0;
                  dcnt_next  = '0;
               end else begin
                  bcnt_next = bcnt + ONE;
               end
            end
            DEG: begin
               if (pcnt == DEG_LAST) begin
                  pcnt_next = '0;
                  dcnt_next = dcnt_inc;
                  if (dcnt_inc == cur_angle) state_next = LOW;
               end else begin
                  pcnt_next = pcnt + ONE;
               end
            end
            default: ;
         endcase
      end
      pwm_next = (state_next == BASE) || (state_next == DEG);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         fcnt        <= '0;
         en_q        <= 1'b0;
         cur_angle   <= 8'd60;
         pwm         <= 1'b0;
         frame_start <= 1'b0;
         bcnt        <= '0;
         pcnt        <= '0;
         dcnt        <= '0;
      end else begin
         state       <= state_next;
         fcnt        <= (fcnt == FRAME_LAST) ? '0 : fcnt + ONE;
         frame_start <= boundary;
         pwm         <= pwm_next;
         bcnt        <= bcnt_next;
         pcnt        <= pcnt_next;
         dcnt        <= dcnt_next;
         if (boundary) begin
            cur_angle <= clamp_angle(angle);
            en_q      <= en;
         end
      end
   end

endmodule
